// File: rtl/debounce_sync_pkg.sv
// Shared definitions for input-conditioning blocks: debounce state encoding and
// default filter parameters.
package debounce_sync_pkg;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 16;

  // Bit 1 is the accepted level and bit 0 marks a pending qualification.
  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    CHECK_HIGH = 2'b01,
    IDLE_HIGH  = 2'b10,
    CHECK_LOW  = 2'b11
  } state_e;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// The stages are plain flops with nothing between them.
module sync_chain
  import debounce_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be 2 or more");
  end

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a bouncy asynchronous input into a clean level
// with single-cycle rise/fall pulses.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic enable,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  if (SYNC_STAGES < 2 || CNT_W < 1 || STABLE_CYCLES < 1 ||
      (STABLE_CYCLES >> CNT_W) != 0) begin : g_bad_params
    $error("debounce_sync: illegal SYNC_STAGES/STABLE_CYCLES/CNT_W combination");
  end

  localparam logic             STABLE_ONE = (STABLE_CYCLES == 1);
  localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (raw_in),
    .q    (w_s)
  );

  // Comparing against STABLE_CYCLES-1 keeps the counter below the limit, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (enable && w_s) begin
          if (STABLE_ONE) begin
            w_state_nxt = IDLE_HIGH;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = CHECK_HIGH;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      CHECK_HIGH: begin
        if (!enable || !w_s) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_M1) begin
          w_state_nxt = IDLE_HIGH;
          w_rise_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (enable && !w_s) begin
          if (STABLE_ONE) begin
            w_state_nxt = IDLE_LOW;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = CHECK_LOW;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      CHECK_LOW: begin
        if (!enable || w_s) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_M1) begin
          w_state_nxt = IDLE_LOW;
          w_fall_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign level_out  = r_state[1];
  assign busy       = r_state[0];
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule
